// File: rtl/tff_counter.sv
// Falling-edge counter built from T-type cells: toggle-mask, up, down and load modes.
// Optional macro TFF_COUNTER_SAT_EN makes the up/down boundaries saturate instead of wrap.
module tff_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

`ifdef TFF_COUNTER_SAT_EN
    localparam logic [WIDTH-1:0] UP_BOUND_TGT = MAX_VAL;
    localparam logic [WIDTH-1:0] DN_BOUND_TGT = '0;
`else
    localparam logic [WIDTH-1:0] UP_BOUND_TGT = '0;
    localparam logic [WIDTH-1:0] DN_BOUND_TGT = MAX_VAL;
`endif

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic [WIDTH-1:0] tv_s;
    logic [WIDTH-1:0] masked_s;
    logic             tc_next_s;

    // Bit i toggles when every lower bit is 1 (ripple-carry of a T-cell up counter).
    function automatic logic [WIDTH-1:0] up_tv_f(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] tv;
        logic             run;
        run = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            tv[i] = run;
            run   = run & v[i];
        end
        return tv;
    endfunction

    // Bit i toggles when every lower bit is 0 (borrow chain of a T-cell down counter).
    function automatic logic [WIDTH-1:0] down_tv_f(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] tv;
        logic             run;
        run = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            tv[i] = run;
            run   = run & ~v[i];
        end
        return tv;
    endfunction

    // Toggle vector that moves q to an arbitrary target, clamped to MAX_VAL.
    function automatic logic [WIDTH-1:0] goto_tv_f(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
        logic [WIDTH-1:0] lim;
        if (tgt > MAX_VAL) begin
            lim = MAX_VAL;
        end else begin
            lim = tgt;
        end
        return cur ^ lim;
    endfunction

    // Next-state toggle vector and terminal-count decode.
    always_comb begin
        tv_s      = '0;
        tc_next_s = 1'b0;
        masked_s  = q_r ^ t;
        if (en) begin
            case (mode)
                MODE_TOGGLE: begin
                    if (masked_s > MAX_VAL) begin
                        tv_s = q_r ^ MAX_VAL;
                    end else begin
                        tv_s = t;
                    end
                end
                MODE_UP: begin
                    if (q_r == MAX_VAL) begin
                        tv_s      = q_r ^ UP_BOUND_TGT;
                        tc_next_s = 1'b1;
                    end else begin
                        tv_s = up_tv_f(q_r);
                    end
                end
                MODE_DOWN: begin
                    if (q_r == '0) begin
                        tv_s      = q_r ^ DN_BOUND_TGT;
                        tc_next_s = 1'b1;
                    end else begin
                        tv_s = down_tv_f(q_r);
                    end
                end
                MODE_LOAD: begin
                    tv_s = goto_tv_f(q_r, d);
                end
                default: begin
                    tv_s = '0;
                end
            endcase
        end else begin
            tv_s      = '0;
            tc_next_s = 1'b0;
        end
    end

    // T-cell state and terminal-count register, updated on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            q_r  <= '0;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_r ^ tv_s;
            tc_r <= tc_next_s;
        end
    end

    assign q  = q_r;
    assign tc = tc_r;

endmodule

// File: tb/tb_tff_counter.sv
// Table-driven plus randomized scoreboard bench for tff_counter (WIDTH=4, MAX_VAL=9).
module tb_tff_counter;

    localparam int unsigned WIDTH = 4;
    localparam logic [3:0]  MAXV  = 4'd9;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [3:0] t;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_tc;
    } vec_t;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] t = 4'd0;
    logic [3:0] d = 4'd0;
    logic [3:0] q;
    logic       tc;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    exp_t sb[$];

    tff_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d), .q(q), .tc(tc)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic e, input logic [1:0] m,
                                input logic [3:0] tt, input logic [3:0] dd,
                                input logic [3:0] eq, input logic etc);
        vecs.push_back('{rst: r, en: e, mode: m, t: tt, d: dd, exp_q: eq, exp_tc: etc});
    endfunction

    // Arithmetic reference model, deliberately not toggle-vector based.
    function automatic exp_t model(input logic [3:0] cq, input logic r, input logic e,
                                   input logic [1:0] m, input logic [3:0] tt, input logic [3:0] dd);
        exp_t o;
        logic [3:0] x;
        o.q = cq;
        o.tc = 1'b0;
        if (r) begin
            o.q = 4'd0;
        end else if (e) begin
            case (m)
                2'b00: begin x = cq ^ tt; o.q = (x > MAXV) ? MAXV : x; end
                2'b01: begin
                    if (cq == MAXV) begin
`ifdef TFF_COUNTER_SAT_EN
                        o.q = MAXV;
`else
                        o.q = 4'd0;
`endif
                        o.tc = 1'b1;
                    end else o.q = cq + 4'd1;
                end
                2'b10: begin
                    if (cq == 4'd0) begin
`ifdef TFF_COUNTER_SAT_EN
                        o.q = 4'd0;
`else
                        o.q = MAXV;
`endif
                        o.tc = 1'b1;
                    end else o.q = cq - 4'd1;
                end
                default: o.q = (dd > MAXV) ? MAXV : dd;
            endcase
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] tt, input logic [3:0] dd, input exp_t ex,
                        input string name);
        exp_t got;
        rst = r; en = e; mode = m; t = tt; d = dd;
        sb.push_back(ex);
        @(negedge clk);
        @(posedge clk);
        got = sb.pop_front();
        checks++;
        if (q !== got.q) begin
            failures++;
            $display("FAIL %s q: actual=%0d required=%0d", name, q, got.q);
        end
        checks++;
        if (tc !== got.tc) begin
            failures++;
            $display("FAIL %s tc: actual=%0d required=%0d", name, tc, got.tc);
        end
    endtask

    initial begin
        exp_t ex;
        logic [3:0] mq;
        logic r, e;
        logic [1:0] m;
        logic [3:0] tt, dd;

        add(1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'd0, 1'b0);  // reset state
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd5, 4'd5, 1'b0);
        add(1'b1, 1'b1, 2'b01, 4'hF, 4'hF, 4'd0, 1'b0);  // reset mid-count
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd8, 4'd8, 1'b0);
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd9, 1'b0);
`ifdef TFF_COUNTER_SAT_EN
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd9, 1'b1);
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd9, 1'b1);
`else
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd0, 1'b1);
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd1, 1'b0);
`endif
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd1, 4'd1, 1'b0);
        add(1'b0, 1'b1, 2'b10, 4'h0, 4'd0, 4'd0, 1'b0);
`ifdef TFF_COUNTER_SAT_EN
        add(1'b0, 1'b1, 2'b10, 4'h0, 4'd0, 4'd0, 1'b1);
        add(1'b0, 1'b0, 2'b10, 4'h0, 4'd0, 4'd0, 1'b0);
`else
        add(1'b0, 1'b1, 2'b10, 4'h0, 4'd0, 4'd9, 1'b1);
        add(1'b0, 1'b0, 2'b10, 4'h0, 4'd0, 4'd9, 1'b0);  // en low holds, clears tc
`endif
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'hC, 4'd9, 1'b0);  // load clamp
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd3, 4'd3, 1'b0);
        add(1'b0, 1'b1, 2'b00, 4'h5, 4'd0, 4'd6, 1'b0);
        add(1'b0, 1'b1, 2'b00, 4'hF, 4'd0, 4'd9, 1'b0);
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd6, 4'd6, 1'b0);
        add(1'b0, 1'b1, 2'b00, 4'h8, 4'd0, 4'd9, 1'b0);  // toggle clamp
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd4, 4'd4, 1'b0);
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd5, 1'b0);  // alternating modes
        add(1'b0, 1'b1, 2'b10, 4'h0, 4'd0, 4'd4, 1'b0);
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd5, 1'b0);
        add(1'b0, 1'b1, 2'b10, 4'h0, 4'd0, 4'd4, 1'b0);
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd9, 4'd9, 1'b0);
        add(1'b0, 1'b0, 2'b01, 4'h0, 4'd0, 4'd9, 1'b0);
`ifdef TFF_COUNTER_SAT_EN
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd9, 1'b1);
`else
        add(1'b0, 1'b1, 2'b01, 4'h0, 4'd0, 4'd0, 1'b1);
`endif
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd9, 4'd9, 1'b0);
        add(1'b1, 1'b1, 2'b01, 4'h0, 4'd0, 4'd0, 1'b0);  // reset at boundary
        add(1'b0, 1'b1, 2'b00, 4'h0, 4'd0, 4'd0, 1'b0);
        add(1'b0, 1'b1, 2'b11, 4'h0, 4'd0, 4'd0, 1'b0);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            ex.q = vecs[i].exp_q;
            ex.tc = vecs[i].exp_tc;
            step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].t, vecs[i].d, ex,
                 $sformatf("vec%0d", i));
        end

        mq = 4'd0;
        for (int n = 0; n < 300; n++) begin
            r  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 7) != 0);
            m  = 2'($urandom_range(0, 3));
            tt = 4'($urandom_range(0, 15));
            dd = 4'($urandom_range(0, 15));
            ex = model(mq, r, e, m, tt, dd);
            mq = ex.q;
            step(r, e, m, tt, dd, ex, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
